// File: rtl/layer_argmax_13_32.sv
// Streaming argmax over M signed T-bit activations per vector; reports index and value of the maximum.
// The next vector accumulates while the previous result waits on the output handshake.
module layer_argmax_13_32 #(
  parameter int M    = 13,
  parameter int T    = 32,
  parameter int logM = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [logM-1:0] class_out,
  output logic [T-1:0]    max_out
);

  logic [logM-1:0]     cnt;
  logic signed [T-1:0] run_max;
  logic [logM-1:0]     run_idx;

  logic signed [T-1:0] cand_max;
  logic [logM-1:0]     cand_idx;
  logic                last, s_xfer;

  assign last    = (cnt == logM'(M-1));
  // Only the last word stalls: it needs the result slot, which frees if the result leaves this cycle.
  assign s_ready = reset && !(last && m_valid && !m_ready);
  assign s_xfer  = s_valid && s_ready;

  always_comb begin
    cand_max = run_max;
    cand_idx = run_idx;
    if (cnt == '0) begin
      cand_max = $signed(data_in);
      cand_idx = '0;
    end else if ($signed(data_in) > run_max) begin
      // Strict compare keeps the lowest index on ties.
      cand_max = $signed(data_in);
      cand_idx = cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      class_out <= '0;
      max_out   <= '0;
      m_valid   <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (s_xfer) begin
        if (last) begin
          max_out   <= cand_max;
          class_out <= cand_idx;
          m_valid   <= 1'b1;
          cnt       <= '0;
        end else begin
          run_max <= cand_max;
          run_idx <= cand_idx;
          cnt     <= cnt + logM'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_argmax_13_32.sv
// Scoreboard bench for layer_argmax_13_32: directed corner vectors plus randomized gaps/back-pressure.
module tb_layer_argmax_13_32;
  localparam int M = 13, T = 32, LOGM = 4;

  logic            clk = 1'b0, reset = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [T-1:0]    data_in = '0;
  logic            s_ready, m_valid;
  logic [LOGM-1:0] class_out;
  logic [T-1:0]    max_out;

  layer_argmax_13_32 #(.M(M), .T(T)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .class_out(class_out), .max_out(max_out)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned idx; logic [31:0] val; } exp_t;
  exp_t        sb[$];
  logic [31:0] cur[$];
  int          n_chk = 0, n_err = 0;
  bit          rand_rdy = 1'b0;
  logic [31:0] v[M];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t argmax(input logic [31:0] q[$]);
    exp_t e;
    e.idx = 0; e.val = q[0];
    for (int i = 1; i < q.size(); i++)
      if ($signed(q[i]) > $signed(e.val)) begin e.val = q[i]; e.idx = i; end
    return e;
  endfunction

  // Handshakes are judged at the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      sb.delete(); cur.delete();
    end else begin
      if (m_valid && m_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_class", 64'(class_out), 64'(e.idx));
          chk("sb_max", 64'(max_out), 64'(e.val));
        end
      end
      if (s_valid && s_ready) begin
        cur.push_back(data_in);
        if (cur.size() == M) begin sb.push_back(argmax(cur)); cur.delete(); end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    bit ok = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1; data_in = d;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge clk); ok = s_ready; tick();
    end
    s_valid = 1'b0;
    if (!ok) chk("s_ready_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_vec(input int first, input int last_w);
    for (int i = first; i <= last_w; i++) send_word(v[i], 0);
  endtask

  task automatic drain();
    rand_rdy = 1'b0; m_ready = 1'b1;
    for (int w = 0; w < 50 && sb.size() != 0; w++) tick();
    tick();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_class", 64'(class_out), 64'd0);
    chk("rst_max", 64'(max_out), 64'd0);
    tick(); reset = 1'b1; m_ready = 1'b1;
    tick();

    // Tie between idx 1 and 7 resolves to the lower index; latency 1.
    foreach (v[i]) v[i] = 0;
    v[0] = 5; v[1] = 9; v[2] = 2; v[7] = 9;
    send_vec(0, 11);
    chk("t1_mv_pre", 64'(m_valid), 64'd0);
    send_vec(12, 12);
    chk("t1_mv", 64'(m_valid), 64'd1);
    chk("t1_class", 64'(class_out), 64'd1);
    chk("t1_max", 64'(max_out), 64'd9);
    tick();

    foreach (v[i]) v[i] = 0;
    send_vec(0, 12);
    chk("t2_zero_class", 64'(class_out), 64'd0);
    chk("t2_zero_max", 64'(max_out), 64'd0);
    foreach (v[i]) v[i] = -8;
    v[0] = -3; v[1] = -1; v[2] = -7;
    send_vec(0, 12);
    chk("t2_neg_class", 64'(class_out), 64'd1);
    chk("t2_neg_max", 64'(max_out), 64'(32'hFFFF_FFFF));
    tick();

    // Back-pressure: last word of B stalls until A's result is taken, then both move on one edge.
    m_ready = 1'b0;
    foreach (v[i]) v[i] = i;
    v[3] = 50;
    send_vec(0, 12);
    foreach (v[i]) v[i] = 10 + i;
    v[12] = 77;
    send_vec(0, 11);
    s_valid = 1'b1; data_in = v[12];
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_s_ready", 64'(s_ready), 64'd0);
      chk("t3_hold_mv", 64'(m_valid), 64'd1);
      chk("t3_hold_class", 64'(class_out), 64'd3);
      chk("t3_hold_max", 64'(max_out), 64'd50);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_s_ready", 64'(s_ready), 64'd1);
    tick();
    s_valid = 1'b0;
    chk("t3_mv_kept", 64'(m_valid), 64'd1);
    chk("t3_class_b", 64'(class_out), 64'd12);
    chk("t3_max_b", 64'(max_out), 64'd77);
    drain();

    // Random gaps, random back-pressure, values narrow half the time to force ties.
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      bit narrow = 1'($urandom_range(0, 1));
      for (int i = 0; i < M; i++)
        send_word(narrow ? 32'($urandom_range(0, 7)) - 32'd3 : $urandom,
                  $urandom_range(0, 1) ? 0 : $urandom_range(1, 2));
    end
    drain();

    // Asynchronous reset mid-vector with a result pending.
    m_ready = 1'b0;
    foreach (v[i]) v[i] = 100 - i;
    send_vec(0, 12);
    send_vec(0, 5);
    chk("t5_pending", 64'(m_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_mv", 64'(m_valid), 64'd0);
    chk("t5_rst_s_ready", 64'(s_ready), 64'd0);
    tick(); tick();
    reset = 1'b1; m_ready = 1'b1;
    tick();
    foreach (v[i]) v[i] = (i % 2 == 0) ? 32'h7FFF_FFFE : 32'h8000_0000;
    v[12] = 32'h7FFF_FFFF;
    send_vec(0, 12);
    chk("t5_class", 64'(class_out), 64'd12);
    chk("t5_max", 64'(max_out), 64'd2147483647);
    tick();

    foreach (v[i]) v[i] = (i % 3 == 0) ? 100 : 100 - i;
    send_vec(0, 12);
    chk("t6_first_class", 64'(class_out), 64'd0);
    chk("t6_first_max", 64'(max_out), 64'd100);
    foreach (v[i]) v[i] = 0;
    v[12] = 1;
    send_vec(0, 12);
    chk("t6_last_class", 64'(class_out), 64'd12);
    chk("t6_last_max", 64'(max_out), 64'd1);
    drain();
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
